// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [1:0]       op_r;
    logic             sign_a;
    logic             sign_b;

    logic             accept;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] fast_res;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] final_res;
    logic             last_iter;

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign in_signed = ~op[0];
    assign a_neg     = in_signed & A[WIDTH-1];
    assign b_neg     = in_signed & B[WIDTH-1];
    // INT_MIN negates to itself, which is exactly its unsigned magnitude
    assign a_abs     = a_neg ? (~A + 1'b1) : A;
    assign b_abs     = b_neg ? (~B + 1'b1) : B;
    assign div_zero  = (B == '0);
    assign overflow  = in_signed && (A == INT_MIN) && (B == '1);

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = op[1] ? A : '1;
        end else begin
            fast_res = op[1] ? '0 : INT_MIN;
        end
    end

    // One restoring step; the trial's top bit is its sign
    assign shifted   = {rem, quo[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvsr};
    assign q_next    = {quo[WIDTH-2:0], ~trial[WIDTH]};
    assign r_next    = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_fix     = (~op_r[0] & (sign_a ^ sign_b)) ? (~q_next + 1'b1) : q_next;
    assign r_fix     = (~op_r[0] & sign_a) ? (~r_next + 1'b1) : r_next;
    assign final_res = op_r[1] ? r_fix : q_fix;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            op_r   <= 2'b00;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            Result <= '0;
        end else begin
            case (state)
                S_CALC: begin
                    rem <= r_next;
                    quo <= q_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        Result <= final_res;
                        state  <= S_DONE;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_r   <= op;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        rem    <= '0;
                        quo    <= a_abs;
                        dvsr   <= b_abs;
                        cnt    <= '0;
                        if (div_zero || overflow) begin
                            Result <= fast_res;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    seq_divider #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    typedef struct {
        int          acc;
        int          due;
        logic [31:0] res;
        bit          slow;
    } exp_t;

    exp_t        q[$];
    int          cyc;
    int          checks;
    int          errors;
    logic [31:0] last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endfunction

    function automatic logic [31:0] model_res(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            OP_DIV:  return sa / sb;
            OP_DIVU: return a / b;
            OP_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Every cycle with reset released: done, busy and Result against the expectation queue
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_done;
            logic exp_busy;
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            exp_busy = 1'b0;
            for (int i = 0; i < q.size(); i++)
                if (q[i].slow && q[i].acc <= cyc && cyc < q[i].due) exp_busy = 1'b1;
            chk("done", {31'b0, done}, {31'b0, exp_done});
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            if (exp_done) begin
                chk("result", Result, q[0].res);
                last_res = q[0].res;
                void'(q.pop_front());
            end else begin
                chk("result_hold", Result, last_res);
            end
        end
    end

    // Call positioned just after a negedge; the next posedge accepts
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] req, output int due);
        exp_t e;
        chk("model_pin", model_res(o, a, b), req);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        e.acc  = cyc + 1;
        e.due  = cyc + model_lat(o, a, b);
        e.res  = req;
        e.slow = (model_lat(o, a, b) > 1);
        due    = e.due;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_to(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cyc < target) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d required=%0d", cyc, target);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] req);
        int d;
        @(negedge clk);
        issue(o, a, b, req, d);
        wait_to(d + 1);
    endtask

    initial begin
        int d1;
        int d2;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        last_res = 32'h0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        A        = 32'h0;
        B        = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_result", Result, 32'h0);
        #1 rst_n = 1'b1;

        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op(OP_REMU, 32'd5, 32'd0, 32'd5);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op(OP_DIV,  32'h8000_0000, 32'd3, 32'hD555_5556);
        run_op(OP_REM,  32'h8000_0000, 32'd3, 32'hFFFF_FFFE);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        run_op(OP_REMU, 32'd3, 32'hFFFF_FFFF, 32'd3);
        run_op(OP_DIVU, 32'd0, 32'd5, 32'd0);
        run_op(OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE);

        // Start during CALC must be ignored
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd7, 32'd142, d1);
        wait_to(d1 - 33 + 10);
        op    = OP_REMU;
        A     = 32'd55;
        B     = 32'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_to(d1 + 1);

        // Back-to-back: start held in the DONE cycle
        @(negedge clk);
        issue(OP_DIV, 32'hFFFF_FC18, 32'd10, 32'hFFFF_FF9C, d1);
        wait_to(d1);
        issue(OP_REMU, 32'd1001, 32'd10, 32'd1, d2);
        chk("b2b_latency", d2 - d1, 32'd33);
        wait_to(d2 + 1);

        // Asynchronous reset in the middle of a CALC
        @(negedge clk);
        issue(OP_DIVU, 32'd12345, 32'd11, 32'd1122, d1);
        wait_to(d1 - 33 + 14);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        last_res = 32'h0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_result", Result, 32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative 32-bit integer divider implementing the RV32M DIV, DIVU, REM and REMU instructions.
- Sits beside the ALU add/subtract datapath in the execute stage and handles the operations that stall the pipeline.
- Uses restoring division, one quotient bit per clock, with a start/busy/done handshake.
- Handles the divide-by-zero and signed-overflow cases in a fast path.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when busy=0
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0])
A  input  WIDTH  dividend, sampled with start
B  input  WIDTH  divisor, sampled with start
busy  output  1  iteration in progress
done  output  1  one-cycle pulse, Result valid
Result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE; busy=0, done=0, Result=0; iteration counter and internal registers are cleared.
- Reset asserted mid-operation aborts the operation; no done pulse is produced for it.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Start acceptance: start is accepted at a rising edge when the state is IDLE or DONE. In CALC, start is ignored and the operands are not re-sampled.
- Setup at the accept edge:
  - Latch op and the operand signs.
  - Signed ops (DIV, REM): take |A| and |B| in two's complement. |0x80000000| = 0x80000000 as unsigned.
  - Unsigned ops (DIVU, REMU): use A and B raw.
  - Clear the partial remainder; counter=0.
- Fast path, decided combinationally at the accept edge, goes straight to DONE (done visible 1 cycle after the accept edge):
  - B==0: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow (op DIV or REM, A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, one iteration per edge:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - Form the trial value rem - divisor as a WIDTH+1-bit subtraction.
  - If the trial is non-negative: rem = trial and the quotient LSB = 1; otherwise restore and the quotient LSB = 0.
  - counter increments; at the edge completing iteration WIDTH, apply sign fix-up, load Result and go to DONE.
  - Normal latency: done visible WIDTH+1 (33) cycles after the accept edge.
- Sign fix-up (signed ops only):
  - Quotient is negated iff sign(A)^sign(B).
  - Remainder is negated iff sign(A). The remainder takes the dividend's sign.
  - Result is truncated to WIDTH bits.
- Result holding: Result holds its value after done until the next completion; it does not change during CALC.
- Back-to-back: start asserted in the DONE cycle is accepted; the done pulse still occurs and the next operation begins in the same cycle.
- Result width: all arithmetic is internally WIDTH+1 bits. There are no flags outputs.

Test Plan:
- DIVU A=100, B=7 -> busy high 32 cycles, done at cycle 33, Result=14; REMU same operands -> Result=2.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Result=0xFFFFFFFD (-3); REM same operands -> Result=0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
- Divide by zero: DIV 5/0 -> Result=0xFFFFFFFF; REMU 5/0 -> Result=5; both with done 1 cycle after start and busy never high.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> Result=0x80000000; REM same -> 0; both with latency 1. DIVU 0x80000000/0xFFFFFFFF -> 0 via the normal 33-cycle path.
- Start pulsed with new operands at cycle 10 of a CALC -> ignored; the original result is delivered at cycle 33. Start held in the DONE cycle -> second operation accepted, done again 33 cycles later.
- rst_n dropped at cycle 15 of a CALC, asynchronously between edges -> busy, done and Result go to 0 immediately; no done pulse afterward; a fresh DIVU 9/3 after release -> Result=3.
